// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RV32I control path: opcodes, FSM state codes,
// opcode classes and the datapath mux-select encodings.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_LUI      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_JALR2    = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [2:0] CLS_LOAD   = 3'd0;
    localparam logic [2:0] CLS_STORE  = 3'd1;
    localparam logic [2:0] CLS_R      = 3'd2;
    localparam logic [2:0] CLS_I      = 3'd3;
    localparam logic [2:0] CLS_LUI    = 3'd4;
    localparam logic [2:0] CLS_BRANCH = 3'd5;
    localparam logic [2:0] CLS_JAL    = 3'd6;
    localparam logic [2:0] CLS_JALR   = 3'd7;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/op_class_dec.sv
// Opcode classifier: maps the 7-bit opcode to an instruction class, the immediate
// format and a legal flag. Shared by the DECODE dispatch and the ImmSrc output.
module op_class_dec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] op_class,
    output logic [1:0] imm_src,
    output logic       legal
);

    always_comb begin
        op_class = CLS_R;
        imm_src  = IMM_I;
        legal    = 1'b1;
        case (op)
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  begin op_class = CLS_STORE;  imm_src = IMM_S; end
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LUI:    op_class = CLS_LUI;
            OP_BRANCH: begin op_class = CLS_BRANCH; imm_src = IMM_B; end
            OP_JAL:    begin op_class = CLS_JAL;    imm_src = IMM_J; end
            OP_JALR:   op_class = CLS_JALR;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/writeback,
// waits on memory, traps illegal opcodes and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode class
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | load data read, held until memory ready
// MEMWRITE | store write, held until memory ready; retires
// MEMWB    | rd <= load data; retires
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// LUI      | ALU passes U-immediate
// ALUWB    | rd <= ALUOut; retires
// BRANCH   | compare rs1/rs2, PC <= target when taken; retires
// JAL      | PC <= OldPC+imm, ALUOut <= OldPC+4
// JALR     | ALUOut <= rs1+imm
// JALR2    | PC <= ALUOut, ALUOut <= OldPC+4
// TRAP     | sticky illegal-opcode halt, left only through reset
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit TRAP_EN       = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             Taken,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             Branch,
    output logic             LUIOp,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             Trap,
    output logic             Retire,
    output logic [CNT_W-1:0] InstRet,
    output logic [3:0]       State
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] state, next_state;
    logic [2:0] op_class;
    logic [1:0] imm_src;
    logic       legal;
    logic       rdy;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic       branch, lui_op, trap, retire;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    op_class_dec u_dec (
        .op       (op),
        .op_class (op_class),
        .imm_src  (imm_src),
        .legal    (legal)
    );

    assign rdy = MemReady | ~USE_MEM_READY;

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        lui_op     = 1'b0;
        trap       = 1'b0;
        retire     = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (rdy) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (!legal) begin
                    if (TRAP_EN) begin
                        next_state = S_TRAP;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end else begin
                    case (op_class)
                        CLS_LOAD, CLS_STORE: next_state = S_MEMADR;
                        CLS_R:               next_state = S_EXECR;
                        CLS_I:               next_state = S_EXECI;
                        CLS_LUI:             next_state = S_LUI;
                        CLS_BRANCH:          next_state = S_BRANCH;
                        CLS_JAL:             next_state = S_JAL;
                        default:             next_state = S_JALR;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = (op_class == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (rdy) next_state = S_MEMWB;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b  = SRCB_IMM;
                lui_op     = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                pc_write   = Taken;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = S_JALR2;
            end
            // PC takes rs1+imm from ALUOut while the ALU forms the link address
            S_JALR2: begin
                pc_write   = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                next_state = S_ALUWB;
            end
            S_TRAP:  trap = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            InstRet <= '0;
        end else begin
            state <= next_state;
            if (retire) InstRet <= InstRet + CNT_ONE;
        end
    end

    // Every control output is forced low while reset is held
    assign PCWrite   = pc_write  & rst_n;
    assign AdrSrc    = adr_src   & rst_n;
    assign MemRead   = mem_read  & rst_n;
    assign MemWrite  = mem_write & rst_n;
    assign IRWrite   = ir_write  & rst_n;
    assign RegWrite  = reg_write & rst_n;
    assign Branch    = branch    & rst_n;
    assign LUIOp     = lui_op    & rst_n;
    assign Trap      = trap      & rst_n;
    assign Retire    = retire    & rst_n;
    assign ResultSrc = result_src & {2{rst_n}};
    assign ALUSrcA   = alu_src_a  & {2{rst_n}};
    assign ALUSrcB   = alu_src_b  & {2{rst_n}};
    assign ALUOp     = alu_op     & {2{rst_n}};
    assign ImmSrc    = imm_src    & {2{rst_n}};
    assign State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle scoreboard of every control output built from
// instruction-level micro-op sequences, plus a wrap/no-trap instance with CNT_W=4.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_ILL   = 7'b1111111;

    typedef struct packed {
        logic pcw, adr, mrd, mwr, irw, rgw, br, lui;
        logic [1:0] rs, sa, sb, aop, imm;
        logic trap, ret;
    } ov_t;
    typedef struct { ov_t v; logic [31:0] instret; } exp_t;
    typedef struct { logic [6:0] op; logic taken; logic mr; } stim_t;

    logic clk = 1'b0, rst_n, rst1_n;
    logic [6:0] op, op1;
    logic Taken, Taken1, MemReady;
    logic PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Branch, LUIOp, Trap, Retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [31:0] InstRet;
    logic [3:0] State;
    logic PCWrite1, AdrSrc1, MemRead1, MemWrite1, IRWrite1, RegWrite1, Branch1, LUIOp1, Trap1, Retire1;
    logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1;
    logic [3:0] InstRet1, State1;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .Taken(Taken), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .Branch(Branch), .LUIOp(LUIOp),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .Trap(Trap), .Retire(Retire), .InstRet(InstRet), .State(State)
    );

    multicycle_ctrl #(.USE_MEM_READY(1'b0), .TRAP_EN(1'b0), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst1_n), .op(op1), .Taken(Taken1), .MemReady(MemReady),
        .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .MemRead(MemRead1), .MemWrite(MemWrite1),
        .IRWrite(IRWrite1), .RegWrite(RegWrite1), .Branch(Branch1), .LUIOp(LUIOp1),
        .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1),
        .ImmSrc(ImmSrc1), .Trap(Trap1), .Retire(Retire1), .InstRet(InstRet1), .State(State1)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int vectors = 0, miscompares = 0;
    logic mon_en = 1'b0;
    logic [6:0] m_op;
    logic m_taken;
    logic [31:0] m_instret;
    logic [6:0] legal_ops[8];
    logic [6:0] seq1[17];

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            T_STORE: return 2'b01;
            T_BR:    return 2'b10;
            T_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic ov_t ctl(input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] aop, input logic [1:0] rs);
        ov_t v = '0;
        v.sa = sa; v.sb = sb; v.aop = aop; v.rs = rs;
        return v;
    endfunction

    function automatic ov_t sample();
        ov_t v;
        v.pcw = PCWrite; v.adr = AdrSrc; v.mrd = MemRead; v.mwr = MemWrite;
        v.irw = IRWrite; v.rgw = RegWrite; v.br = Branch; v.lui = LUIOp;
        v.rs = ResultSrc; v.sa = ALUSrcA; v.sb = ALUSrcB; v.aop = ALUOp; v.imm = ImmSrc;
        v.trap = Trap; v.ret = Retire;
        return v;
    endfunction

    function automatic int lat(input logic [6:0] o);
        case (o)
            T_LOAD, T_JALR:              return 5;
            T_STORE, T_R, T_I, T_LUI, T_JAL: return 4;
            T_BR:                        return 3;
            default:                     return 2;
        endcase
    endfunction

    // One cycle of expected behaviour plus the stimulus driven during it
    task automatic push_cyc(input ov_t v, input logic mr);
        exp_t e;
        stim_t s;
        v.imm = imm_of(m_op);
        e.v = v; e.instret = m_instret;
        s.op = m_op; s.taken = m_taken; s.mr = mr;
        exp_q.push_back(e);
        stim_q.push_back(s);
        if (v.ret) m_instret++;
    endtask

    task automatic alu_wb();
        ov_t v = ctl(2'b00, 2'b00, 2'b00, 2'b00);
        v.rgw = 1'b1; v.ret = 1'b1;
        push_cyc(v, rbit());
    endtask

    task automatic plan_ins(input logic [6:0] o, input logic tk, input int fw, input int mw);
        ov_t v;
        v = ctl(2'b00, 2'b10, 2'b00, 2'b10);
        v.mrd = 1'b1;
        repeat (fw) push_cyc(v, 1'b0);
        v.irw = 1'b1; v.pcw = 1'b1;
        push_cyc(v, 1'b1);
        m_op = o; m_taken = tk;
        push_cyc(ctl(2'b01, 2'b01, 2'b00, 2'b00), rbit());
        case (o)
            T_LOAD: begin
                push_cyc(ctl(2'b10, 2'b01, 2'b00, 2'b00), rbit());
                v = '0; v.adr = 1'b1; v.mrd = 1'b1;
                repeat (mw) push_cyc(v, 1'b0);
                push_cyc(v, 1'b1);
                v = ctl(2'b00, 2'b00, 2'b00, 2'b01); v.rgw = 1'b1; v.ret = 1'b1;
                push_cyc(v, rbit());
            end
            T_STORE: begin
                push_cyc(ctl(2'b10, 2'b01, 2'b00, 2'b00), rbit());
                v = '0; v.adr = 1'b1; v.mwr = 1'b1;
                repeat (mw) push_cyc(v, 1'b0);
                v.ret = 1'b1;
                push_cyc(v, 1'b1);
            end
            T_R:   begin push_cyc(ctl(2'b10, 2'b00, 2'b10, 2'b00), rbit()); alu_wb(); end
            T_I:   begin push_cyc(ctl(2'b10, 2'b01, 2'b10, 2'b00), rbit()); alu_wb(); end
            T_LUI: begin
                v = ctl(2'b00, 2'b01, 2'b00, 2'b00); v.lui = 1'b1;
                push_cyc(v, rbit()); alu_wb();
            end
            T_BR: begin
                v = ctl(2'b10, 2'b00, 2'b01, 2'b00); v.br = 1'b1; v.pcw = tk; v.ret = 1'b1;
                push_cyc(v, rbit());
            end
            T_JAL: begin
                v = ctl(2'b01, 2'b10, 2'b00, 2'b00); v.pcw = 1'b1;
                push_cyc(v, rbit()); alu_wb();
            end
            T_JALR: begin
                push_cyc(ctl(2'b10, 2'b01, 2'b00, 2'b00), rbit());
                v = ctl(2'b01, 2'b10, 2'b00, 2'b00); v.pcw = 1'b1;
                push_cyc(v, rbit()); alu_wb();
            end
            default: begin
                v = '0; v.trap = 1'b1;
                repeat (100) push_cyc(v, rbit());
            end
        endcase
    endtask

    task automatic apply_one();
        stim_t s = stim_q.pop_front();
        op = s.op; Taken = s.taken; MemReady = s.mr;
    endtask

    task automatic run_plan(input int limit);
        int n = 0;
        while (stim_q.size() > 0 && n < limit) begin
            apply_one();
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (sample() !== '0 || InstRet !== 32'd0) begin
            miscompares++;
            $display("FAIL %s: outputs %h instret %0d, expected all zero", name, sample(), InstRet);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en && exp_q.size() > 0) begin
            exp_t e;
            ov_t g;
            e = exp_q.pop_front();
            g = sample();
            vectors++;
            if (g !== e.v || InstRet !== e.instret) begin
                miscompares++;
                $display("FAIL cycle t=%0t: outputs %h instret %0d, expected %h instret %0d",
                         $time, g, InstRet, e.v, e.instret);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cyc, budget, ntrap;
        logic ld;
        legal_ops = '{T_LOAD, T_STORE, T_R, T_I, T_LUI, T_BR, T_JAL, T_JALR};
        rst_n = 1'b0; rst1_n = 1'b0;
        op = 7'h00; op1 = 7'h00; Taken = 1'b0; Taken1 = 1'b0; MemReady = 1'b0;
        m_op = 7'h00; m_taken = 1'b0; m_instret = 32'd0;
        #3;
        check_zero("reset");
        check_val("reset_small_instret", {28'd0, InstRet1}, 32'd0);

        // directed cases first, then a random mix, ending in an illegal opcode
        plan_ins(T_R, 1'b0, 0, 0);
        plan_ins(T_LOAD, 1'b0, 0, 3);
        plan_ins(T_STORE, 1'b0, 0, 2);
        plan_ins(T_BR, 1'b0, 0, 0);
        plan_ins(T_BR, 1'b1, 0, 0);
        plan_ins(T_JAL, 1'b0, 1, 0);
        plan_ins(T_JALR, 1'b0, 2, 0);
        plan_ins(T_LUI, 1'b0, 0, 0);
        repeat (150)
            plan_ins(legal_ops[$urandom_range(0, 7)], rbit(),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        plan_ins(T_ILL, 1'b0, 0, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_plan(100000);

        rst_n = 1'b0;
        #1 check_zero("trap_cleared");
        @(posedge clk); #1 check_zero("reset_hold");

        // jalr aborted by reset in its second state
        m_instret = 32'd0;
        rst_n = 1'b1;
        plan_ins(T_JALR, 1'b0, 1, 0);
        run_plan(4);
        apply_one();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_zero("jalr_abort");
        stim_q.delete();
        exp_q.delete();
        @(posedge clk); #1 check_zero("jalr_abort_hold");

        m_instret = 32'd0;
        rst_n = 1'b1;
        plan_ins(T_R, 1'b0, 0, 0);
        run_plan(100);
        check_val("instret_after_abort", InstRet, 32'd1);
        rst_n = 1'b0;
        mon_en = 1'b0;

        // CNT_W=4, MemReady ignored, illegal opcodes retire as NOPs
        MemReady = 1'b0;
        for (int i = 0; i < 17; i++) seq1[i] = legal_ops[$urandom_range(0, 7)];
        seq1[3] = T_ILL;
        seq1[10] = 7'h00;
        k = 0; cyc = 0; budget = 0; ntrap = 0; ld = 1'b0;
        @(posedge clk); #1;
        rst1_n = 1'b1;
        while (k < 17 && budget < 2000) begin
            @(negedge clk);
            budget++;
            cyc++;
            if (Trap1) ntrap++;
            if (IRWrite1) ld = 1'b1;
            if (Retire1) begin
                check_val("small_latency", cyc, lat(seq1[k]));
                k++;
                cyc = 0;
            end
            @(posedge clk); #1;
            if (ld && k < 17) begin
                op1 = seq1[k];
                Taken1 = rbit();
                ld = 1'b0;
            end
        end
        check_val("small_retired", k, 17);
        check_val("small_instret_wrap", {28'd0, InstRet1}, 32'd1);
        check_val("small_no_trap", ntrap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
